// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
// Stereo I2S transmitter: BCLK/LRCLK generation, 64-BCLK frames, one-pair holding register; I2S_TX_UNDERRUN_MUTE_EN selects mute vs repeat on underrun.
// Latency: an accepted pair is loaded at the next 63->0 bit-index wrap and serialized during the following frame (at most 2 frames).
// Backpressure: sample_ready_out is low while the holding register is full; it frees up when a frame loads the pair.
module i2s_tx #(
    parameter int BCLK_HALF_DIV = 16,
    parameter int SAMPLE_WIDTH  = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic                    i2s_bclk_out,
    output logic                    i2s_lrclk_out,
    output logic                    i2s_sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);

    localparam int               DIV_W    = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [4:0]       SW5      = 5'(SAMPLE_WIDTH);

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    bclk_q, bclk_d;
    logic [5:0]              bit_idx_q, bit_idx_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;
    logic                    hold_full_q, hold_full_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d;
    logic [SAMPLE_WIDTH-1:0] frame_r_q, frame_r_d;

    logic                    div_wrap;
    logic                    bclk_fall;
    logic                    frame_load;
    logic                    accept;
    logic [5:0]              next_idx;
    logic [4:0]              slot;
    logic [4:0]              sel;
    logic [SAMPLE_WIDTH-1:0] word;
    logic [SAMPLE_WIDTH-1:0] shifted;
    logic                    slot_bit;

    always_comb begin
        div_wrap   = (div_q == DIV_LAST);
        div_d      = div_wrap ? '0 : div_q + 1'b1;
        bclk_d     = bclk_q ^ div_wrap;
        bclk_fall  = div_wrap & bclk_q;
        next_idx   = bit_idx_q + 6'd1;
        bit_idx_d  = bclk_fall ? next_idx : bit_idx_q;
        frame_load = bclk_fall & (bit_idx_q == 6'd63);

        // Output bits are computed for the index being entered on this falling edge.
        slot     = next_idx[4:0];
        sel      = SW5 - slot;
        word     = next_idx[5] ? frame_r_q : frame_l_q;
        shifted  = word >> sel;
        slot_bit = ((slot != 5'd0) && (slot <= SW5)) ? shifted[0] : 1'b0;

        lrclk_d = bclk_fall ? next_idx[5] : lrclk_q;
        sdata_d = bclk_fall ? slot_bit : sdata_q;

        accept      = sample_valid_in & ~hold_full_q;
        hold_l_d    = accept ? left_in  : hold_l_q;
        hold_r_d    = accept ? right_in : hold_r_q;
        hold_full_d = accept ? 1'b1 : (frame_load ? 1'b0 : hold_full_q);

        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
        if (frame_load) begin
            if (hold_full_q) begin
                frame_l_d = hold_l_q;
                frame_r_d = hold_r_q;
            end else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                frame_l_d = '0;
                frame_r_d = '0;
`else
                frame_l_d = frame_l_q;
                frame_r_d = frame_r_q;
`endif
            end
        end

        frame_start_d = frame_load;
        underrun_d    = frame_load & ~hold_full_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            bit_idx_q     <= '0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            frame_l_q     <= '0;
            frame_r_q     <= '0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            bit_idx_q     <= bit_idx_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
        end
    end

    assign sample_ready_out = ~hold_full_q;
    assign i2s_bclk_out     = bclk_q;
    assign i2s_lrclk_out    = lrclk_q;
    assign i2s_sdata_out    = sdata_q;
    assign frame_start_out  = frame_start_q;
    assign underrun_out     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
// Directed bench for i2s_tx: a rising-BCLK I2S receiver model rebuilds 32-bit slots and compares them with hand-computed slot words.
module tb_i2s_tx;

    localparam int SW = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [SW-1:0] left_in = '0;
    logic [SW-1:0] right_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          sample_ready_out;
    logic          i2s_bclk_out;
    logic          i2s_lrclk_out;
    logic          i2s_sdata_out;
    logic          frame_start_out;
    logic          underrun_out;

    i2s_tx #(.BCLK_HALF_DIV(16), .SAMPLE_WIDTH(SW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .left_in         (left_in),
        .right_in        (right_in),
        .sample_valid_in (sample_valid_in),
        .sample_ready_out(sample_ready_out),
        .i2s_bclk_out    (i2s_bclk_out),
        .i2s_lrclk_out   (i2s_lrclk_out),
        .i2s_sdata_out   (i2s_sdata_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // ---------------- receiver and timing monitor ----------------
    int          cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [31:0] rx_l_q[$];
    logic [31:0] rx_r_q[$];
    logic        fs_ur[$];
    logic [31:0] rx_slot = '0;
    logic [31:0] rx_left = '0;
    int          rx_pos = 0;
    logic        rx_last_lr = 1'b1;
    logic        prev_bclk = 1'b0;
    logic        prev_lr = 1'b0;
    logic        prev_sd = 1'b0;
    int          last_rise = 0;
    int          last_lr_t = 0;
    bit          rise_valid = 0;
    bit          lr_valid = 0;
    int          bclk_bad = 0, lr_bad = 0, edge_bad = 0, ur_orphan = 0;
    int          bclk_meas = 0, lr_meas = 0;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            rx_last_lr = 1'b1;
            rx_pos     = 0;
            rise_valid = 0;
            lr_valid   = 0;
        end else begin
            if (i2s_bclk_out && !prev_bclk) begin
                if (i2s_lrclk_out != rx_last_lr) rx_pos = 0;
                else rx_pos++;
                rx_last_lr = i2s_lrclk_out;
                rx_slot    = {rx_slot[30:0], i2s_sdata_out};
                if (rx_pos == 31) begin
                    if (!i2s_lrclk_out) rx_left = rx_slot;
                    else begin
                        rx_l_q.push_back(rx_left);
                        rx_r_q.push_back(rx_slot);
                    end
                end
                if (rise_valid) begin
                    bclk_meas++;
                    if (cyc - last_rise != 32) bclk_bad++;
                end
                rise_valid = 1;
                last_rise  = cyc;
            end
            if (i2s_lrclk_out != prev_lr) begin
                if (!(prev_bclk && !i2s_bclk_out)) edge_bad++;
                if (lr_valid) begin
                    lr_meas++;
                    if (cyc - last_lr_t != 1024) lr_bad++;
                end
                lr_valid  = 1;
                last_lr_t = cyc;
            end
            if ((i2s_sdata_out != prev_sd) && !(prev_bclk && !i2s_bclk_out)) edge_bad++;
            if (frame_start_out) fs_ur.push_back(underrun_out);
            else if (underrun_out) ur_orphan++;
        end
        prev_bclk = i2s_bclk_out;
        prev_lr   = i2s_lrclk_out;
        prev_sd   = i2s_sdata_out;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] l, input logic [15:0] r, input string name);
        int n = 0;
        left_in = l;
        right_in = r;
        sample_valid_in = 1'b1;
        while (!sample_ready_out && n < 8000) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_accept"}, 32'(sample_ready_out), 32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        chk({name, "_full"}, 32'(sample_ready_out), 32'd0);
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        @(negedge clk_in);
        while (!frame_start_out && n < 4200) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_fs"}, 32'(frame_start_out), 32'd1);
    endtask

    task automatic wait_rx(input int cnt, input string name);
        int n = 0;
        while (rx_l_q.size() < cnt && n < 12000) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_rxcnt"}, 32'(rx_l_q.size() >= cnt), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bclk"},  32'(i2s_bclk_out),     32'd0);
        chk({tag, "_lrclk"}, 32'(i2s_lrclk_out),    32'd0);
        chk({tag, "_sdata"}, 32'(i2s_sdata_out),    32'd0);
        chk({tag, "_fs"},    32'(frame_start_out),  32'd0);
        chk({tag, "_ur"},    32'(underrun_out),     32'd0);
        chk({tag, "_ready"}, 32'(sample_ready_out), 32'd1);
    endtask

    task automatic first_rise(input string tag);
        int n = 0;
        rst_in = 1'b1;
        do begin
            @(negedge clk_in);
            n++;
        end while (!i2s_bclk_out && n < 40);
        chk(tag, 32'(n), 32'd16);
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] ur_l, ur_r;
    int          base;
    int          falls;
    int          n;
    logic        pb;

    initial begin
        vecs[0] = '{16'h8001, 16'h7FFE, 32'h4000_8000, 32'h3FFF_0000};
        vecs[1] = '{16'h1234, 16'h5678, 32'h091A_0000, 32'h2B3C_0000};
        vecs[2] = '{16'hFFFF, 16'h0000, 32'h7FFF_8000, 32'h0000_0000};
        vecs[3] = '{16'h0001, 16'h8000, 32'h0000_8000, 32'h4000_0000};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 32'h52D2_8000, 32'h2D2D_0000};
        vecs[5] = '{16'h1234, 16'h5678, 32'h091A_0000, 32'h2B3C_0000};
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        ur_l = 32'h0;
        ur_r = 32'h0;
`else
        ur_l = vecs[5].el;
        ur_r = vecs[5].er;
`endif

        // Reset state and first BCLK edge timing
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("rst");
        first_rise("first_rise");

        // Back-to-back pairs: frame 0 is silent, then one pair per frame, then an underrun
        for (int i = 0; i < 6; i++) send(vecs[i].l, vecs[i].r, $sformatf("vec%0d", i));
        wait_rx(8, "stream");
        chk("frame0_l", rx_l_q[0], 32'h0);
        chk("frame0_r", rx_r_q[0], 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("vec%0d_lslot", i), rx_l_q[i+1], vecs[i].el);
            chk($sformatf("vec%0d_rslot", i), rx_r_q[i+1], vecs[i].er);
        end
        chk("ur_frame_l", rx_l_q[7], ur_l);
        chk("ur_frame_r", rx_r_q[7], ur_r);
        chk("fs_count", 32'(fs_ur.size() >= 7), 32'd1);
        for (int i = 0; i < 6; i++) chk($sformatf("fs%0d_no_ur", i), 32'(fs_ur[i]), 32'd0);
        chk("fs6_ur", 32'(fs_ur[6]), 32'd1);

        // Valid raised in the frame_start cycle with the holding register empty
        wait_fs("late");
        chk("late_ur", 32'(underrun_out), 32'd1);
        chk("late_ready", 32'(sample_ready_out), 32'd1);
        base = rx_l_q.size();
        send(16'h1357, 16'h2468, "late");
        wait_fs("late_next");
        chk("late_next_no_ur", 32'(underrun_out), 32'd0);
        wait_rx(base + 2, "late");
        chk("late_ur_l", rx_l_q[base], ur_l);
        chk("late_ur_r", rx_r_q[base], ur_r);
        chk("late_pair_l", rx_l_q[base+1], 32'h09AB_8000);
        chk("late_pair_r", rx_r_q[base+1], 32'h1234_0000);

        // Reset at bit index 20 with a pair held
        wait_fs("hold");
        send(16'hDEAD, 16'hBEEF, "held");
        falls = 0;
        n = 0;
        pb = i2s_bclk_out;
        while (falls < 20 && n < 1000) begin
            @(negedge clk_in);
            if (pb && !i2s_bclk_out) falls++;
            pb = i2s_bclk_out;
            n++;
        end
        chk("idx20_reached", 32'(falls), 32'd20);
        rst_in = 1'b0;
        #1;
        check_reset_outputs("midrst");
        rx_l_q.delete();
        rx_r_q.delete();
        fs_ur.delete();
        repeat (3) @(negedge clk_in);
        first_rise("rerise");
        wait_rx(3, "post");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post%0d_l", i), rx_l_q[i], 32'h0);
            chk($sformatf("post%0d_r", i), rx_r_q[i], 32'h0);
        end
        chk("post_first_ur", 32'(fs_ur[0]), 32'd1);

        // Clock / word-select timing collected across the whole run
        chk("bclk_period_bad", 32'(bclk_bad), 32'd0);
        chk("bclk_measured", 32'(bclk_meas > 100), 32'd1);
        chk("lrclk_half_bad", 32'(lr_bad), 32'd0);
        chk("lrclk_measured", 32'(lr_meas > 4), 32'd1);
        chk("edge_not_falling", 32'(edge_bad), 32'd0);
        chk("underrun_orphan", 32'(ur_orphan), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001: The module SHALL have parameter BCLK_HALF_DIV, default 16, giving clk_in cycles per BCLK half-period (BCLK = clk_in/32, 98.304 MHz -> 3.072 MHz).
REQ-002: The module SHALL have parameter SAMPLE_WIDTH, default 16, giving signed sample width, legal range 8..31.
REQ-003: Port clk_in, input, 1 bit: the single clock (audio_clk domain).
REQ-004: Port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005: Port left_in, input, SAMPLE_WIDTH bits: signed left sample.
REQ-006: Port right_in, input, SAMPLE_WIDTH bits: signed right sample.
REQ-007: Port sample_valid_in, input, 1 bit: the left_in/right_in pair is valid.
REQ-008: Port sample_ready_out, output, 1 bit: the holding register is empty; the pair is accepted on valid & ready.
REQ-009: Port i2s_bclk_out, output, 1 bit: bit clock to the DAC.
REQ-010: Port i2s_lrclk_out, output, 1 bit: word select; 0 = left, 1 = right.
REQ-011: Port i2s_sdata_out, output, 1 bit: serial data, MSB first.
REQ-012: Port frame_start_out, output, 1 bit: 1-cycle pulse when a new frame is loaded into the shift register.
REQ-013: Port underrun_out, output, 1 bit: 1-cycle pulse when a frame starts with the holding register empty.

Function
REQ-014: A divider counter (0..BCLK_HALF_DIV-1) SHALL toggle i2s_bclk_out on wrap; a falling BCLK edge is the only point at which lrclk, sdata and the bit index change.
REQ-015: A 6-bit bit index SHALL advance on each falling BCLK edge, giving 64 BCLKs per frame (48 kHz at defaults, 2048 clk_in per frame).
REQ-016: i2s_lrclk_out SHALL be 0 for bit indices 0..31 and 1 for 32..63, changing on the falling edge that enters index 0 or 32.
REQ-017: Standard I2S format SHALL apply: in each 32-bit slot, slot bits 1..SAMPLE_WIDTH carry the sample MSB..LSB; slot bit 0 and the bits after the LSB carry 0.
REQ-018: Holding register: when sample_ready_out & sample_valid_in, left_in/right_in SHALL be captured and the register marked full; sample_ready_out = NOT full.
REQ-019: Frame load: on the clk_in cycle where the bit index wraps 63->0, the holding contents SHALL be moved to the shift register, the holding register marked empty, and frame_start_out pulsed.
REQ-020: If the holding register is empty at frame load, underrun_out SHALL pulse and the underrun data policy (REQ-027/028) SHALL apply.
REQ-021: On a handshake in the same cycle as a frame load, the load SHALL use the pre-cycle holding state, and the accepted pair SHALL occupy the holding register for the next frame.
REQ-022: Accepted samples SHALL appear at i2s_sdata_out at most 2 frames after acceptance; samples SHALL never be dropped or reordered.

Reset
REQ-023: While rst_in = 0, bclk, lrclk, sdata, frame_start_out and underrun_out SHALL be 0.
REQ-024: While rst_in = 0, the divider and bit index SHALL be 0, the holding register empty, the shift register zero, and sample_ready_out 1.
REQ-025: After reset release, the first BCLK rising edge SHALL occur BCLK_HALF_DIV cycles later; the bit-index-0 frame transmits zeros and counts as no underrun.
REQ-026: Reset asserted mid-frame SHALL immediately abort the frame and discard any held sample.

Configuration
REQ-027: With I2S_TX_UNDERRUN_MUTE_EN defined, an underrun frame SHALL transmit zeros on both channels.
REQ-028: Without I2S_TX_UNDERRUN_MUTE_EN, an underrun frame SHALL retransmit the last loaded left/right pair (zeros if none since reset).

Verification
REQ-029: After reset release, i2s_bclk_out period SHALL be 32 clk_in cycles, i2s_lrclk_out period 2048 cycles with 50% duty, and transitions SHALL occur only on falling BCLK.
REQ-030: Send left=16'h8001, right=16'h7FFE, sampled on rising BCLK: the left slot SHALL read 0,1000000000000001,0x15; the right slot SHALL read 0,0111111111111110,0x15.
REQ-031: Hold valid high with an incrementing counter: received pairs SHALL be 0,1,2,... in order, with sample_ready_out low exactly while full and no underrun_out pulses.
REQ-032: Send one pair 16'h1234/16'h5678 then stop: underrun_out SHALL pulse on the next frame_start_out, sending zeros (MUTE_EN) or 1234/5678 again (no macro).
REQ-033: Raise valid in the exact cycle of frame_start_out with the holding register empty: underrun_out SHALL pulse, and the pair SHALL be sent in the following frame.
REQ-034: Assert rst_in low at bit index 20 with a pair held: outputs SHALL go 0 at once, and after release the held pair SHALL never be transmitted.
